tlul_reg_responder: RTL
=======================

# tlul_reg_responder

TL-UL device-side responder. Accepts one request on the A channel of a `tlul_pkg::tl_h2d_t` bus. Converts it into a single-word register read or write strobe, and returns an AccessAck or AccessAckData on the D channel of `tlul_pkg::tl_d2h_t`. It sits at the leaf of the fabric, in front of every register file. Only one transaction is outstanding at a time, and malformed requests get an error response without touching the registers.

## Interface
- `RegAw`, default 8: register address width. Byte address; `reg_addr_o` = `a_address[RegAw-1:0]` with bits [1:0] forced to 0.
- `clk_i`  in  1  clock. One clock; all logic on the rising edge.
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `tl_i`  in  `tl_h2d_t`  host request plus `d_ready`.
- `tl_o`  out  `tl_d2h_t`  response plus `a_ready`.
- `reg_we_o`  out  1  write strobe.
- `reg_re_o`  out  1  read strobe.
- `reg_addr_o`  out  RegAw  word-aligned address.
- `reg_wdata_o`  out  32  write data.
- `reg_be_o`  out  4  byte enables (`a_mask`).
- `reg_rdata_i`  in  32  read data, sampled when not busy.
- `reg_error_i`  in  1  register-side error, sampled with rdata.
- `reg_busy_i`  in  1  register stall. Holds the strobe asserted.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE:** `a_ready`=1. On `a_valid`, the request is accepted.
  - It latches opcode, size, source, address, mask and data.
  - It runs the checks below. Pass goes to ACCESS; fail goes to RESP with error=1.
- **ACCESS:** `a_ready`=0.
  - `reg_re_o`=1 for Get; `reg_we_o`=1 for PutFullData or PutPartialData.
  - While `reg_busy_i`=1, the state holds and the strobe stays high.
  - When `reg_busy_i`=0, it captures `reg_rdata_i` and `reg_error_i`, then goes to RESP.
- **RESP:** `d_valid`=1 and `a_ready`=0. Fields are held stable until `d_ready`, then the FSM returns to IDLE.
- **Request checks.** Any one of these sets error:
  - opcode is not in {PutFullData, PutPartialData, Get};
  - `a_size` > 2;
  - `a_address[1:0]` is not 0;
  - PutFullData with `a_mask` not equal to 4'hF;
  - `a_mask` is 0 on a Put;
  - `a_user.instr_type` is not 4'h0 (instruction fetch from registers).
- **Response fields.**
  - `d_opcode` = AccessAckData for Get, otherwise AccessAck.
  - `d_size` and `d_source` echo the request.
  - `d_param` = 0 and `d_sink` = 0.
  - `d_error` = check error OR `reg_error_i`.
- **`d_data` values.**
  - Successful Get: rdata.
  - Errored Get with an instr_type violation: `DataWhenInstrError`.
  - Other errored Get: `DataWhenError`.
  - Put: 0.

## Timing
- Handshake at cycle 0 with a passing check and no busy: strobe in cycle 1, `d_valid` in cycle 2.
- Each busy cycle adds one cycle.
- Check failure: no strobe is issued and `d_valid` rises in cycle 1.
- `a_ready` is combinational from state (IDLE only). The adapter does not accept back-to-back requests.
  - Minimum request interval is 3 cycles: 2 cycles for an error.
- If `d_ready`=1 on the first RESP cycle, the FSM returns to IDLE in the next cycle.
- Strobes are exactly one cycle per access when not busy and never repeat for the same request.
- **Reset values:**
  - state IDLE, so `a_ready`=1;
  - `d_valid`=0, strobes 0;
  - all latched fields 0;
  - `d_user` per Configuration.
- Reset asserted mid-ACCESS or mid-RESP: strobes and `d_valid` drop asynchronously and the response is discarded.
- `a_valid` while not in IDLE is ignored; the host holds it.

## Configuration
- `TLUL_RSP_INTG_EN` defined:
  - `d_user.rsp_intg` = 7 ECC bits from `prim_secded_inv_64_57_enc` over the zero-extended `tl_d2h_rsp_intg_t` {opcode, size, error};
  - `d_user.data_intg` = 7 bits from `prim_secded_inv_39_32_enc` over `d_data`;
  - both are computed from the registered response and are valid whenever `d_valid`=1.
- Undefined: `d_user` = `TL_D_USER_DEFAULT`, with all ones in both fields, and no encoders are instantiated.

## Test plan
- **Get:** Get at 0x10 with `reg_rdata_i`=0xCAFEF00D and busy=0.
  - `reg_re_o` high in cycle 1 only.
  - `d_valid` in cycle 2 with AccessAckData, data 0xCAFEF00D, `d_error`=0, source echoed.
- **PutPartialData with busy stall:** PutPartialData at 0x08, mask 4'b0011, data 0x1234, busy held for 3 cycles.
  - `reg_we_o` high for 4 cycles with `reg_be_o`=0011.
  - `d_valid` in cycle 5 with AccessAck and data 0.
- **Misaligned address:** Get at 0x06.
  - No strobe.
  - `d_valid` in cycle 1 with `d_error`=1 and `d_data`=0xFFFFFFFF.
- **Bad mask or instruction fetch:** PutFullData with mask 4'h7, then a Get with instr_type=4'h6.
  - Both return `d_error`=1 with no strobe.
  - The Get returns data 0.
- **Backpressure:** `d_ready`=0 for 5 cycles in RESP.
  - `d_valid` and all fields stay stable and `a_ready` stays 0.
  - After `d_ready`, `a_ready`=1 the next cycle.
- **Reset mid-ACCESS:** `rst_ni` low mid-ACCESS.
  - `reg_we_o` low immediately and `d_valid` stays 0.
  - After release, `a_ready`=1, and a new Get completes normally.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL bus payload types, opcodes and response constants shared by the register responder.
// TLUL_RSP_INTG_EN additionally provides the inverted SECDED encoders used for response integrity.
package tlul_pkg;

    localparam int unsigned TlAw   = 32;
    localparam int unsigned TlDw   = 32;
    localparam int unsigned TlDbw  = 4;
    localparam int unsigned TlAiw  = 8;
    localparam int unsigned TlDiw  = 1;
    localparam int unsigned TlSzw  = 2;
    localparam int unsigned TlOpw  = 3;
    localparam int unsigned IntgW  = 7;

    // A-channel opcodes
    localparam logic [TlOpw-1:0] PutFullData    = 3'h0;
    localparam logic [TlOpw-1:0] PutPartialData = 3'h1;
    localparam logic [TlOpw-1:0] Get            = 3'h4;

    // D-channel opcodes
    localparam logic [TlOpw-1:0] AccessAck      = 3'h0;
    localparam logic [TlOpw-1:0] AccessAckData  = 3'h1;

    localparam logic [TlDw-1:0] DataWhenError      = 32'hFFFF_FFFF;
    localparam logic [TlDw-1:0] DataWhenInstrError = 32'h0000_0000;

    typedef struct packed {
        logic [3:0]       instr_type;
        logic [IntgW-1:0] cmd_intg;
        logic [IntgW-1:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic             a_valid;
        logic [TlOpw-1:0] a_opcode;
        logic [2:0]       a_param;
        logic [TlSzw-1:0] a_size;
        logic [TlAiw-1:0] a_source;
        logic [TlAw-1:0]  a_address;
        logic [TlDbw-1:0] a_mask;
        logic [TlDw-1:0]  a_data;
        tl_a_user_t       a_user;
        logic             d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic [IntgW-1:0] rsp_intg;
        logic [IntgW-1:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic             d_valid;
        logic [TlOpw-1:0] d_opcode;
        logic [2:0]       d_param;
        logic [TlSzw-1:0] d_size;
        logic [TlAiw-1:0] d_source;
        logic [TlDiw-1:0] d_sink;
        logic [TlDw-1:0]  d_data;
        tl_d_user_t       d_user;
        logic             d_error;
        logic             a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic [TlOpw-1:0] opcode;
        logic [TlSzw-1:0] size;
        logic             error;
    } tl_d2h_rsp_intg_t;

    localparam tl_d_user_t TL_D_USER_DEFAULT = '{rsp_intg: '1, data_intg: '1};

`ifdef TLUL_RSP_INTG_EN
    function automatic logic [63:0] prim_secded_inv_64_57_enc(input logic [56:0] data_i);
        logic [63:0] cw;
        cw     = 64'(data_i);
        cw[57] = ^(cw & 64'h0103FFF800007FFF);
        cw[58] = ^(cw & 64'h017C1FF801FF801F);
        cw[59] = ^(cw & 64'h01BDE1F87E0781E1);
        cw[60] = ^(cw & 64'h01DEEE3B8E388E22);
        cw[61] = ^(cw & 64'h01EF76CDB2C93244);
        cw[62] = ^(cw & 64'h01F7BB56D5525488);
        cw[63] = ^(cw & 64'h01FBDDA769A46910);
        cw     = cw ^ 64'h5400000000000000;
        return cw;
    endfunction

    function automatic logic [38:0] prim_secded_inv_39_32_enc(input logic [31:0] data_i);
        logic [38:0] cw;
        cw     = 39'(data_i);
        cw[32] = ^(cw & 39'h002606BD25);
        cw[33] = ^(cw & 39'h00DEBA8050);
        cw[34] = ^(cw & 39'h00413D89AA);
        cw[35] = ^(cw & 39'h0031234ED1);
        cw[36] = ^(cw & 39'h00C2C1323B);
        cw[37] = ^(cw & 39'h002DCC624C);
        cw[38] = ^(cw & 39'h0098505586);
        cw     = cw ^ 39'h2A00000000;
        return cw;
    endfunction
`endif

endpackage

// File: rtl/tlul_reg_responder.sv
// TL-UL leaf responder: one outstanding request turned into a single register read/write strobe.
// Define TLUL_RSP_INTG_EN to drive d_user with SECDED response/data integrity instead of the default.
module tlul_reg_responder
    import tlul_pkg::*;
#(
    parameter int unsigned RegAw = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  tl_h2d_t          tl_i,
    output tl_d2h_t          tl_o,
    output logic             reg_we_o,
    output logic             reg_re_o,
    output logic [RegAw-1:0] reg_addr_o,
    output logic [31:0]      reg_wdata_o,
    output logic [3:0]       reg_be_o,
    input  logic [31:0]      reg_rdata_i,
    input  logic             reg_error_i,
    input  logic             reg_busy_i
);

    localparam int unsigned WordAw = RegAw - 2;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [TlOpw-1:0]    opcode_q, opcode_d;
    logic [TlSzw-1:0]    size_q, size_d;
    logic [TlAiw-1:0]    source_q, source_d;
    logic [WordAw-1:0]   waddr_q, waddr_d;
    logic [TlDbw-1:0]    mask_q, mask_d;
    logic [TlDw-1:0]     wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic                dvalid_q, dvalid_d;
    logic                derror_q, derror_d;
    logic [TlDw-1:0]     ddata_q, ddata_d;

    logic                req_get, req_put, chk_instr, chk_err;
    logic [TlOpw-1:0]    rsp_opcode;
    tl_d_user_t          d_user;
    logic                unused_tl;

    // Whole request is observed; unneeded fields (param, upper address, A-side integrity) are sunk here.
    assign unused_tl = ^tl_i;

    // Request legality checks, evaluated on the accepting cycle
    always_comb begin
        req_get   = (tl_i.a_opcode == Get);
        req_put   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
        chk_instr = (tl_i.a_user.instr_type != 4'h0);
        chk_err   = !(req_get || req_put)
                  || (tl_i.a_size > 2'd2)
                  || (tl_i.a_address[1:0] != 2'b00)
                  || ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != 4'hF))
                  || (req_put && (tl_i.a_mask == 4'h0))
                  || chk_instr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            opcode_q <= '0;
            size_q   <= '0;
            source_q <= '0;
            waddr_q  <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            dvalid_q <= 1'b0;
            derror_q <= 1'b0;
            ddata_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            size_q   <= size_d;
            source_q <= source_d;
            waddr_q  <= waddr_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            dvalid_q <= dvalid_d;
            derror_q <= derror_d;
            ddata_q  <= ddata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        size_d   = size_q;
        source_d = source_q;
        waddr_d  = waddr_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        re_d     = re_q;
        dvalid_d = dvalid_q;
        derror_d = derror_q;
        ddata_d  = ddata_q;

        unique case (state_q)
            StIdle: begin
                if (tl_i.a_valid) begin
                    opcode_d = tl_i.a_opcode;
                    size_d   = tl_i.a_size;
                    source_d = tl_i.a_source;
                    waddr_d  = tl_i.a_address[RegAw-1:2];
                    mask_d   = tl_i.a_mask;
                    wdata_d  = tl_i.a_data;
                    if (chk_err) begin
                        // Malformed request skips the register access entirely
                        state_d  = StResp;
                        dvalid_d = 1'b1;
                        derror_d = 1'b1;
                        if (!req_get)       ddata_d = '0;
                        else if (chk_instr) ddata_d = DataWhenInstrError;
                        else                ddata_d = DataWhenError;
                    end else begin
                        state_d = StAccess;
                        re_d    = req_get;
                        we_d    = req_put;
                    end
                end
            end
            StAccess: begin
                if (!reg_busy_i) begin
                    state_d  = StResp;
                    re_d     = 1'b0;
                    we_d     = 1'b0;
                    dvalid_d = 1'b1;
                    derror_d = reg_error_i;
                    if (opcode_q != Get) ddata_d = '0;
                    else if (reg_error_i) ddata_d = DataWhenError;
                    else                  ddata_d = reg_rdata_i;
                end
            end
            StResp: begin
                if (tl_i.d_ready) begin
                    state_d  = StIdle;
                    dvalid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rsp_opcode = (opcode_q == Get) ? AccessAckData : AccessAck;

`ifdef TLUL_RSP_INTG_EN
    tl_d2h_rsp_intg_t rsp_intg;
    logic [63:0]      rsp_cw;
    logic [38:0]      data_cw;
    logic             unused_cw;

    assign rsp_intg  = '{opcode: rsp_opcode, size: size_q, error: derror_q};
    assign rsp_cw    = prim_secded_inv_64_57_enc(57'(rsp_intg));
    assign data_cw   = prim_secded_inv_39_32_enc(ddata_q);
    assign d_user    = '{rsp_intg: rsp_cw[63:57], data_intg: data_cw[38:32]};
    assign unused_cw = ^{rsp_cw[56:0], data_cw[31:0]};
`else
    assign d_user = TL_D_USER_DEFAULT;
`endif

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = dvalid_q;
        tl_o.d_opcode = rsp_opcode;
        tl_o.d_param  = 3'd0;
        tl_o.d_size   = size_q;
        tl_o.d_source = source_q;
        tl_o.d_sink   = '0;
        tl_o.d_data   = ddata_q;
        tl_o.d_user   = d_user;
        tl_o.d_error  = derror_q;
        tl_o.a_ready  = (state_q == StIdle);
    end

    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;
    assign reg_addr_o  = {waddr_q, 2'b00};
    assign reg_wdata_o = wdata_q;
    assign reg_be_o    = mask_q;

endmodule
